hand_display: RTL and testbench
===============================

# hand_display

Parametrised successor to the single-digit card decoder. It buffers up to NUM_SLOTS dealt cards for one hand, drives one seven-segment digit per slot plus a score digit, and accepts cards through a valid/ready handshake from the dealer FSM. It sits between the dealer/datapath and the board HEX displays, and is instanced once for the player hand and once for the banker hand.

## Interface
- NUM_SLOTS, 3: card slots in the hand (1..6); slot 0 drives the lowest 7 bits of HEX.
- BLINK_PERIOD, 25_000_000: clk cycles per blink half-period (used only with blink compiled in).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- deal_valid  in  1  dealer presents a card.
- deal_card  in  4  card code: 1=A … 10=10, 11=J, 12=Q, 13=K; 0/14/15 = no card.
- deal_ready  out  1  block can accept a card.
- clear  in  1  synchronous hand clear.
- count  out  $clog2(NUM_SLOTS+1)  cards held.
- full  out  1  count == NUM_SLOTS.
- score  out  4  baccarat hand value 0..9.
- HEX  out  7*NUM_SLOTS  active-low segments {g..a} per slot.
- HEX_SCORE  out  7  active-low segments for score.

## Operation
- Storage: slots[0..NUM_SLOTS-1], 4 bits each; count; state.
- FSM states EMPTY, FILLING, FULL:
  - EMPTY→FILLING on accept when NUM_SLOTS>1; EMPTY→FULL on accept when NUM_SLOTS==1.
  - FILLING→FULL when the accept brings count to NUM_SLOTS.
  - Any state→EMPTY on clear.
- deal_ready = (state != FULL) && !clear; it is combinational and independent of deal_valid/deal_card.
- Accept = deal_valid && deal_ready. On accept, slots[count] <= deal_card and count increments.
- Codes 0/14/15 are accepted and stored as-is: they occupy a slot, display blank and score 0 points.
- clear: all slots <= 0, count <= 0. It takes priority over a same-cycle deal_valid, which is not accepted.
- Points: 1..9 give face value; 10..13 and illegal codes give 0. score = (sum of points) mod 10. The sum width is 6 bits, which holds 6×9=54, so no overflow.
- Glyphs: 0/14/15 blank (7'b1111111); A,2–9 standard; 10 shown as "0"; J, Q (as "q") and K (as "H"-like) use the existing team glyph set. Score digits 0..9 use standard numerals.
- Reset: slots=0, count=0, state EMPTY, deal_ready=1 (once reset deasserts), full=0, score=0, HEX all 1s, HEX_SCORE = glyph "0".

## Timing
- Accept at edge k: slots/count/full updated at edge k; deal_ready low from edge k if full.
- score, HEX, HEX_SCORE are registered, so they reflect the new card after edge k+1. Latency is 1 cycle from slot write to display.
- clear at edge k: count=0 and deal_ready=1 after edge k; displays blank and score shows 0 after edge k+1.
- Back-to-back accepts, one per cycle, are allowed until full.
- deal_valid held while full: no write, count stays at NUM_SLOTS.
- Reset asserted mid-hand returns all state immediately, with no dependence on clk.

## Configuration
- CARD_BLINK_EN defined:
  - The most recently accepted slot alternates glyph/blank every BLINK_PERIOD cycles. The blink counter and phase restart on each accept, and the glyph is shown first.
  - Only the newest slot blinks. Blinking stops on clear or reset, and no slot blinks when count==0.
  - HEX_SCORE never blinks.
- CARD_BLINK_EN undefined: no blink counter is synthesised and all glyphs are static.

## Structure
- Package card_pkg:
  - typedef card_t (4-bit);
  - glyph constants for NONE, A..K and score digits 0..9;
  - function card_points(card_t) returning 4 bits;
  - typedef hand_state_t {EMPTY, FILLING, FULL}.
- Sub-module card_glyph: combinational card_t→7-bit active-low decoder, instanced NUM_SLOTS times. The score digit decoder is a package function.

## Test plan
- Reset, NUM_SLOTS=3 → count=0, full=0, deal_ready=1, HEX=21'h1FFFFF, score=0, HEX_SCORE = "0".
- Deal 7, 8 back-to-back → count=2; score=5 one cycle after second accept; slot1 glyph = EIGHT.
- Deal K, 9, 4 → full=1, deal_ready=0, score=3; a fourth deal_valid with card 2 held 5 cycles leaves count=3, score=3.
- Deal 15 then 6 → both accepted, slot0 blank, score=6.
- deal_valid and clear in the same cycle with a partial hand → no accept, count=0, HEX all blank after 1 cycle.
- CARD_BLINK_EN, BLINK_PERIOD=4: deal A → slot0 shows A for 4 cycles, blank for 4, A again; deal 2 → slot0 steady A, slot1 blinking.

Source files
------------

// File: rtl/card_pkg.sv
// Shared card types, glyph table and scoring helpers for the hand display.
// Glyphs are active-low segments packed {g,f,e,d,c,b,a}.
package card_pkg;

  typedef logic [3:0] card_t;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} hand_state_t;

  localparam logic [6:0] DIGIT_0 = 7'h40;
  localparam logic [6:0] DIGIT_1 = 7'h79;
  localparam logic [6:0] DIGIT_2 = 7'h24;
  localparam logic [6:0] DIGIT_3 = 7'h30;
  localparam logic [6:0] DIGIT_4 = 7'h19;
  localparam logic [6:0] DIGIT_5 = 7'h12;
  localparam logic [6:0] DIGIT_6 = 7'h02;
  localparam logic [6:0] DIGIT_7 = 7'h78;
  localparam logic [6:0] DIGIT_8 = 7'h00;
  localparam logic [6:0] DIGIT_9 = 7'h10;

  localparam logic [6:0] GLYPH_NONE = 7'h7F;
  localparam logic [6:0] GLYPH_A    = DIGIT_1;
  localparam logic [6:0] GLYPH_2    = DIGIT_2;
  localparam logic [6:0] GLYPH_3    = DIGIT_3;
  localparam logic [6:0] GLYPH_4    = DIGIT_4;
  localparam logic [6:0] GLYPH_5    = DIGIT_5;
  localparam logic [6:0] GLYPH_6    = DIGIT_6;
  localparam logic [6:0] GLYPH_7    = DIGIT_7;
  localparam logic [6:0] GLYPH_8    = DIGIT_8;
  localparam logic [6:0] GLYPH_9    = DIGIT_9;
  localparam logic [6:0] GLYPH_10   = DIGIT_0;
  localparam logic [6:0] GLYPH_J    = 7'h61;
  localparam logic [6:0] GLYPH_Q    = 7'h18;
  localparam logic [6:0] GLYPH_K    = 7'h09;

  // Face cards, tens and illegal codes are all worth zero in baccarat.
  function automatic logic [3:0] card_points(input card_t c);
    return (c >= 4'd1 && c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [6:0] score_glyph(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd0:    seg = DIGIT_0;
      4'd1:    seg = DIGIT_1;
      4'd2:    seg = DIGIT_2;
      4'd3:    seg = DIGIT_3;
      4'd4:    seg = DIGIT_4;
      4'd5:    seg = DIGIT_5;
      4'd6:    seg = DIGIT_6;
      4'd7:    seg = DIGIT_7;
      4'd8:    seg = DIGIT_8;
      4'd9:    seg = DIGIT_9;
      default: seg = GLYPH_NONE;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/card_glyph.sv
// Combinational card code to active-low seven-segment decoder.
// Codes 0, 14 and 15 mean "no card" and render blank.
module card_glyph
  import card_pkg::*;
(
  input  logic [3:0] card,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLYPH_NONE;
    case (card)
      4'd1:    seg = GLYPH_A;
      4'd2:    seg = GLYPH_2;
      4'd3:    seg = GLYPH_3;
      4'd4:    seg = GLYPH_4;
      4'd5:    seg = GLYPH_5;
      4'd6:    seg = GLYPH_6;
      4'd7:    seg = GLYPH_7;
      4'd8:    seg = GLYPH_8;
      4'd9:    seg = GLYPH_9;
      4'd10:   seg = GLYPH_10;
      4'd11:   seg = GLYPH_J;
      4'd12:   seg = GLYPH_Q;
      4'd13:   seg = GLYPH_K;
      default: seg = GLYPH_NONE;
    endcase
  end

endmodule

// File: rtl/hand_display.sv
// One baccarat hand: card slots, score and HEX drivers; displays lag slot writes by 1 cycle.
// deal_ready drops while full or during clear; CARD_BLINK_EN blinks the newest slot.
module hand_display
  import card_pkg::*;
#(
  parameter int NUM_SLOTS    = 3,
  parameter int BLINK_PERIOD = 25_000_000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           deal_valid,
  input  logic [3:0]                     deal_card,
  output logic                           deal_ready,
  input  logic                           clear,
  output logic [$clog2(NUM_SLOTS+1)-1:0] count,
  output logic                           full,
  output logic [3:0]                     score,
  output logic [7*NUM_SLOTS-1:0]         HEX,
  output logic [6:0]                     HEX_SCORE
);

  localparam int CW = $clog2(NUM_SLOTS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_SLOTS - 1);

  logic [NUM_SLOTS-1:0][3:0] slots_q, slots_d;
  logic [CW-1:0]             count_q, count_d;
  hand_state_t               state_q, state_d;
  logic [3:0]                score_q, score_d;
  logic [7*NUM_SLOTS-1:0]    hex_q, hex_d;
  logic [6:0]                hex_score_q, hex_score_d;
  logic [NUM_SLOTS-1:0][6:0] glyph;
  logic [5:0]                sum;
  logic                      accept;
  logic                      blank_newest;

  assign deal_ready = (state_q != FULL) && !clear;
  assign accept     = deal_valid && deal_ready;

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    state_d = state_q;
    if (clear) begin
      slots_d = '0;
      count_d = '0;
      state_d = EMPTY;
    end else if (accept) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (i == int'(count_q)) slots_d[i] = deal_card;
      end
      count_d = count_q + 1'b1;
      state_d = (count_q == LAST_SLOT) ? FULL : FILLING;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slots_q <= '0;
      count_q <= '0;
      state_q <= EMPTY;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    card_glyph u_glyph (
      .card (slots_q[g]),
      .seg  (glyph[g])
    );
  end

`ifdef CARD_BLINK_EN
  localparam int BCW = $clog2(BLINK_PERIOD + 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIOD - 1);

  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;

  // Restarting on accept guarantees a fresh card is seen lit first.
  always_comb begin
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (clear || accept) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (count_q != '0) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign blank_newest = blink_phase_q && (count_q != '0);
`else
  logic unused_blink_period;
  assign unused_blink_period = (BLINK_PERIOD > 0);
  assign blank_newest        = 1'b0;
`endif

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sum = sum + 6'(card_points(slots_q[i]));
    end
    score_d     = 4'(sum % 6'd10);
    hex_score_d = score_glyph(score_d);
    hex_d       = '1;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      hex_d[7*i +: 7] = glyph[i];
      if (blank_newest && (i + 1 == int'(count_q))) hex_d[7*i +: 7] = GLYPH_NONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q     <= '0;
      hex_q       <= '1;
      hex_score_q <= DIGIT_0;
    end else begin
      score_q     <= score_d;
      hex_q       <= hex_d;
      hex_score_q <= hex_score_d;
    end
  end

  assign count     = count_q;
  assign full      = (state_q == FULL);
  assign score     = score_q;
  assign HEX       = hex_q;
  assign HEX_SCORE = hex_score_q;

endmodule

// File: tb/tb_hand_display.sv
// Directed bench for hand_display with three slots; the blink scenario runs when CARD_BLINK_EN is defined.
module tb_hand_display;

  logic        clk;
  logic        reset;
  logic        deal_valid;
  logic [3:0]  deal_card;
  logic        deal_ready;
  logic        clear;
  logic [1:0]  count;
  logic        full;
  logic [3:0]  score;
  logic [20:0] HEX;
  logic [6:0]  HEX_SCORE;

  int checks;
  int failures;

  localparam logic [6:0] S_BLANK = 7'h7F;
  localparam logic [6:0] S_0 = 7'h40;
  localparam logic [6:0] S_1 = 7'h79;
  localparam logic [6:0] S_2 = 7'h24;
  localparam logic [6:0] S_3 = 7'h30;
  localparam logic [6:0] S_4 = 7'h19;
  localparam logic [6:0] S_5 = 7'h12;
  localparam logic [6:0] S_6 = 7'h02;
  localparam logic [6:0] S_7 = 7'h78;
  localparam logic [6:0] S_8 = 7'h00;
  localparam logic [6:0] S_9 = 7'h10;
  localparam logic [6:0] S_K = 7'h09;

  hand_display #(
    .NUM_SLOTS    (3),
    .BLINK_PERIOD (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .deal_valid (deal_valid),
    .deal_card  (deal_card),
    .deal_ready (deal_ready),
    .clear      (clear),
    .count      (count),
    .full       (full),
    .score      (score),
    .HEX        (HEX),
    .HEX_SCORE  (HEX_SCORE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    deal_valid = 1'b0;
    deal_card = 4'd0;
    clear = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (deal_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", deal_ready); end
    checks++; if (HEX !== 21'h1FFFFF) begin failures++; $display("FAIL reset_hex got=%h exp=1fffff", HEX); end
    checks++; if (score !== 4'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (HEX_SCORE !== S_0) begin failures++; $display("FAIL reset_hex_score got=%h exp=%h", HEX_SCORE, S_0); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd7;
    step();
    deal_card = 4'd8;
    step();
    deal_valid = 1'b0;
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", count); end
    checks++; if (score !== 4'd7) begin failures++; $display("FAIL b2b_score_lag got=%0d exp=7", score); end
    step();
    checks++; if (score !== 4'd5) begin failures++; $display("FAIL b2b_score got=%0d exp=5", score); end
    checks++; if (HEX[13:7] !== S_8) begin failures++; $display("FAIL b2b_slot1 got=%h exp=%h", HEX[13:7], S_8); end
    checks++; if (HEX[6:0] !== S_7) begin failures++; $display("FAIL b2b_slot0 got=%h exp=%h", HEX[6:0], S_7); end
    checks++; if (HEX_SCORE !== S_5) begin failures++; $display("FAIL b2b_hex_score got=%h exp=%h", HEX_SCORE, S_5); end
  endtask

  task automatic test_full();
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd13;
    step();
    deal_card = 4'd9;
    step();
    deal_card = 4'd4;
    step();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%b exp=1", full); end
    checks++; if (deal_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", deal_ready); end
    deal_card = 4'd2;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (count !== 2'd3) begin failures++; $display("FAIL full_hold_count cyc=%0d got=%0d exp=3", i, count); end
    end
    deal_valid = 1'b0;
    checks++; if (score !== 4'd3) begin failures++; $display("FAIL full_score got=%0d exp=3", score); end
    checks++; if (HEX !== {S_4, S_9, S_K}) begin failures++; $display("FAIL full_hex got=%h exp=%h", HEX, {S_4, S_9, S_K}); end
    checks++; if (HEX_SCORE !== S_3) begin failures++; $display("FAIL full_hex_score got=%h exp=%h", HEX_SCORE, S_3); end
  endtask

  task automatic test_illegal();
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd15;
    step();
    deal_card = 4'd6;
    step();
    deal_valid = 1'b0;
    step();
    checks++; if (count !== 2'd2) begin failures++; $display("FAIL illegal_count got=%0d exp=2", count); end
    checks++; if (HEX[6:0] !== S_BLANK) begin failures++; $display("FAIL illegal_slot0 got=%h exp=%h", HEX[6:0], S_BLANK); end
    checks++; if (HEX[13:7] !== S_6) begin failures++; $display("FAIL illegal_slot1 got=%h exp=%h", HEX[13:7], S_6); end
    checks++; if (score !== 4'd6) begin failures++; $display("FAIL illegal_score got=%0d exp=6", score); end
    deal_valid = 1'b1;
    deal_card = 4'd10;
    step();
    deal_valid = 1'b0;
    step();
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ten_full got=%b exp=1", full); end
    checks++; if (HEX[20:14] !== S_0) begin failures++; $display("FAIL ten_glyph got=%h exp=%h", HEX[20:14], S_0); end
    checks++; if (HEX_SCORE !== S_6) begin failures++; $display("FAIL ten_hex_score got=%h exp=%h", HEX_SCORE, S_6); end
  endtask

  task automatic test_clear_priority();
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd1;
    step();
    deal_card = 4'd5;
    clear = 1'b1;
    #1;
    checks++; if (deal_ready !== 1'b0) begin failures++; $display("FAIL clr_ready_low got=%b exp=0", deal_ready); end
    step();
    clear = 1'b0;
    deal_valid = 1'b0;
    #1;
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", count); end
    checks++; if (deal_ready !== 1'b1) begin failures++; $display("FAIL clr_ready got=%b exp=1", deal_ready); end
    step();
    checks++; if (HEX !== 21'h1FFFFF) begin failures++; $display("FAIL clr_hex got=%h exp=1fffff", HEX); end
    checks++; if (score !== 4'd0) begin failures++; $display("FAIL clr_score got=%0d exp=0", score); end
    checks++; if (HEX_SCORE !== S_0) begin failures++; $display("FAIL clr_hex_score got=%h exp=%h", HEX_SCORE, S_0); end
  endtask

  task automatic test_reset_midhand();
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd3;
    step();
    deal_valid = 1'b0;
    step();
    checks++; if (HEX[6:0] !== S_3) begin failures++; $display("FAIL mid_pre_slot0 got=%h exp=%h", HEX[6:0], S_3); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (count !== 2'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (HEX !== 21'h1FFFFF) begin failures++; $display("FAIL mid_hex got=%h exp=1fffff", HEX); end
    checks++; if (score !== 4'd0) begin failures++; $display("FAIL mid_score got=%0d exp=0", score); end
    step();
    reset = 1'b0;
    step();
  endtask

`ifdef CARD_BLINK_EN
  task automatic test_blink();
    logic [6:0] exp1;
    do_clear();
    deal_valid = 1'b1;
    deal_card = 4'd1;
    step();
    deal_valid = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp1 = (i >= 5 && i <= 8) ? S_BLANK : S_1;
      checks++; if (HEX[6:0] !== exp1) begin failures++; $display("FAIL blink_a cyc=%0d got=%h exp=%h", i, HEX[6:0], exp1); end
    end
    deal_valid = 1'b1;
    deal_card = 4'd2;
    step();
    deal_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      exp1 = (i >= 5) ? S_BLANK : S_2;
      checks++; if (HEX[13:7] !== exp1) begin failures++; $display("FAIL blink_2 cyc=%0d got=%h exp=%h", i, HEX[13:7], exp1); end
      checks++; if (HEX[6:0] !== S_1) begin failures++; $display("FAIL blink_steady cyc=%0d got=%h exp=%h", i, HEX[6:0], S_1); end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_full();
    test_illegal();
    test_clear_priority();
    test_reset_midhand();
`ifdef CARD_BLINK_EN
    test_blink();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
